// File: rtl/channel_scan_sequencer.sv
// Steps a 4-bit channel select from first_ch to last_ch (mod 16), holding each
// channel for at least dwell cycles and until the downstream decoder is ready.
module channel_scan_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] first_ch,
    input  logic [3:0] last_ch,
    input  logic [7:0] dwell,
    input  logic       loop_en,
    input  logic       sel_ready,
    output logic [3:0] sel_out,
    output logic       sel_valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] sel_q, sel_d;
    logic [3:0] first_q, first_d;
    logic [3:0] last_q, last_d;
    logic [7:0] lim_q, lim_d;
    logic [7:0] cnt_q, cnt_d;
    logic       loop_q, loop_d;
    logic       valid_q, valid_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       at_lim;
    logic       advance;

    // lim_q holds dwell_eff-1 so a dwell of 0 behaves like a dwell of 1
    assign at_lim  = (cnt_q == lim_q);
    assign advance = at_lim && sel_ready;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        first_d = first_q;
        last_d  = last_q;
        lim_d   = lim_q;
        loop_d  = loop_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    first_d = first_ch;
                    last_d  = last_ch;
                    lim_d   = (dwell == 8'd0) ? 8'd0 : dwell - 8'd1;
                    loop_d  = loop_en;
                    sel_d   = first_ch;
                    cnt_d   = 8'd0;
                    state_d = SCAN;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            SCAN: begin
                if (stop) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (advance) begin
                    cnt_d = 8'd0;
                    if (sel_q != last_q) begin
                        sel_d = sel_q + 4'd1;
                    end else if (loop_q) begin
                        sel_d = first_q;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else if (!at_lim) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 4'h0;
            first_q <= 4'h0;
            last_q  <= 4'h0;
            lim_q   <= 8'h00;
            loop_q  <= 1'b0;
            cnt_q   <= 8'h00;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            first_q <= first_d;
            last_q  <= last_d;
            lim_q   <= lim_d;
            loop_q  <= loop_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sel_out   = sel_q;
    assign sel_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_channel_scan_sequencer.sv
// Directed bench for channel_scan_sequencer: basic pass, wrap, backpressure,
// looping with stop, start/stop priority, back-to-back start and mid-scan reset.
module tb_channel_scan_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [3:0] first_ch;
    logic [3:0] last_ch;
    logic [7:0] dwell;
    logic       loop_en;
    logic       sel_ready;
    logic [3:0] sel_out;
    logic       sel_valid;
    logic       busy;
    logic       done;

    int nvec;
    int nerr;

    channel_scan_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .first_ch (first_ch),
        .last_ch  (last_ch),
        .dwell    (dwell),
        .loop_en  (loop_en),
        .sel_ready(sel_ready),
        .sel_out  (sel_out),
        .sel_valid(sel_valid),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Any select presented as valid must be a known value.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && sel_valid === 1'b1) begin
            nvec++;
            if ($isunknown(sel_out)) begin
                nerr++;
                $display("FAIL sel_x: sel_out=%b while sel_valid=1", sel_out);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [3:0] f, input logic [3:0] l, input logic [7:0] d, input logic lp);
        first_ch = f;
        last_ch  = l;
        dwell    = d;
        loop_en  = lp;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; sel_ready = 1'b1;
        cfg(4'd0, 4'd0, 8'd0, 1'b0);
        #2;
        nvec++;
        if ({sel_out, sel_valid, busy, done} !== 7'b0) begin
            nerr++;
            $display("FAIL reset_async: got sel=%h v=%b b=%b d=%b want all 0", sel_out, sel_valid, busy, done);
        end
        step();
        nvec++;
        if ({sel_out, sel_valid, busy, done} !== 7'b0) begin
            nerr++;
            $display("FAIL reset_held: got sel=%h v=%b b=%b d=%b want all 0", sel_out, sel_valid, busy, done);
        end
        #1 rst_n = 1'b1;
        step();
        nvec++;
        if ({sel_valid, busy, done} !== 3'b0) begin
            nerr++;
            $display("FAIL reset_idle: got v=%b b=%b d=%b want 0", sel_valid, busy, done);
        end
    endtask

    task automatic test_basic();
        cfg(4'd2, 4'd5, 8'd1, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        // configuration changes during the scan must have no effect
        cfg(4'd9, 4'd10, 8'd7, 1'b1);
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (sel_out !== 4'(2 + i) || sel_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                nerr++;
                $display("FAIL basic_seq[%0d]: got sel=%h v=%b b=%b d=%b want sel=%h v=1 b=1 d=0",
                         i, sel_out, sel_valid, busy, done, 4'(2 + i));
            end
            step();
        end
        nvec++;
        if (done !== 1'b1 || sel_valid !== 1'b0 || busy !== 1'b0 || sel_out !== 4'd5) begin
            nerr++;
            $display("FAIL basic_done: got sel=%h v=%b b=%b d=%b want sel=5 v=0 b=0 d=1", sel_out, sel_valid, busy, done);
        end
        step();
        nvec++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL basic_done_pulse: got d=%b b=%b want d=0 b=0", done, busy);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_seq [4];
        exp_seq = '{4'd14, 4'd15, 4'd0, 4'd1};
        cfg(4'd14, 4'd1, 8'd3, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 3; j++) begin
                nvec++;
                if (sel_out !== exp_seq[i] || sel_valid !== 1'b1 || done !== 1'b0) begin
                    nerr++;
                    $display("FAIL wrap_seq[%0d.%0d]: got sel=%h v=%b d=%b want sel=%h v=1 d=0",
                             i, j, sel_out, sel_valid, done, exp_seq[i]);
                end
                step();
            end
        end
        nvec++;
        if (done !== 1'b1 || sel_valid !== 1'b0 || sel_out !== 4'd1) begin
            nerr++;
            $display("FAIL wrap_done: got sel=%h v=%b d=%b want sel=1 v=0 d=1", sel_out, sel_valid, done);
        end
    endtask

    task automatic test_back_to_back();
        // start raised during the done cycle; single-channel pass with dwell 2
        cfg(4'd6, 4'd6, 8'd2, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 0; j < 2; j++) begin
            nvec++;
            if (sel_out !== 4'd6 || sel_valid !== 1'b1 || busy !== 1'b1) begin
                nerr++;
                $display("FAIL b2b_hold[%0d]: got sel=%h v=%b b=%b want sel=6 v=1 b=1", j, sel_out, sel_valid, busy);
            end
            step();
        end
        nvec++;
        if (done !== 1'b1 || busy !== 1'b0 || sel_out !== 4'd6) begin
            nerr++;
            $display("FAIL b2b_done: got sel=%h b=%b d=%b want sel=6 b=0 d=1", sel_out, busy, done);
        end
        step();
    endtask

    task automatic test_backpressure();
        cfg(4'd7, 4'd8, 8'd0, 1'b0);
        sel_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 0; j < 5; j++) begin
            nvec++;
            if (sel_out !== 4'd7 || sel_valid !== 1'b1) begin
                nerr++;
                $display("FAIL bp_hold[%0d]: got sel=%h v=%b want sel=7 v=1", j, sel_out, sel_valid);
            end
            step();
        end
        sel_ready = 1'b1;
        nvec++;
        if (sel_out !== 4'd7) begin
            nerr++;
            $display("FAIL bp_before_ready: got sel=%h want 7", sel_out);
        end
        step();
        nvec++;
        if (sel_out !== 4'd8 || sel_valid !== 1'b1) begin
            nerr++;
            $display("FAIL bp_advance: got sel=%h v=%b want sel=8 v=1", sel_out, sel_valid);
        end
        step();
        nvec++;
        if (done !== 1'b1 || sel_out !== 4'd8) begin
            nerr++;
            $display("FAIL bp_done: got sel=%h d=%b want sel=8 d=1", sel_out, done);
        end
        step();
    endtask

    task automatic test_loop_stop();
        cfg(4'd3, 4'd4, 8'd1, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            nvec++;
            if (sel_out !== ((i % 2) ? 4'd4 : 4'd3) || done !== 1'b0 || busy !== 1'b1) begin
                nerr++;
                $display("FAIL loop_seq[%0d]: got sel=%h b=%b d=%b want sel=%h b=1 d=0",
                         i, sel_out, busy, done, ((i % 2) ? 4'd4 : 4'd3));
            end
            if (i < 5) step();
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        nvec++;
        if (sel_out !== 4'd4 || sel_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            nerr++;
            $display("FAIL loop_stop: got sel=%h v=%b b=%b d=%b want sel=4 v=0 b=0 d=0", sel_out, sel_valid, busy, done);
        end
        step();
        nvec++;
        if (done !== 1'b0 || busy !== 1'b0 || sel_out !== 4'd4) begin
            nerr++;
            $display("FAIL loop_stop_idle: got sel=%h b=%b d=%b want sel=4 b=0 d=0", sel_out, busy, done);
        end
    endtask

    task automatic test_start_stop_idle();
        cfg(4'd0, 4'd0, 8'd1, 1'b0);
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        nvec++;
        if (busy !== 1'b1 || sel_valid !== 1'b1 || sel_out !== 4'd0) begin
            nerr++;
            $display("FAIL start_wins: got sel=%h v=%b b=%b want sel=0 v=1 b=1", sel_out, sel_valid, busy);
        end
        step();
        nvec++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL start_wins_done: got b=%b d=%b want b=0 d=1", busy, done);
        end
        step();
    endtask

    task automatic test_mid_reset();
        cfg(4'd8, 4'd12, 8'd2, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        nvec++;
        if (sel_out !== 4'd9 || sel_valid !== 1'b1) begin
            nerr++;
            $display("FAIL mr_at9: got sel=%h v=%b want sel=9 v=1", sel_out, sel_valid);
        end
        rst_n = 1'b0;
        #1;
        nvec++;
        if ({sel_out, sel_valid, busy, done} !== 7'b0) begin
            nerr++;
            $display("FAIL mr_async: got sel=%h v=%b b=%b d=%b want all 0", sel_out, sel_valid, busy, done);
        end
        #3 rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            step();
            nvec++;
            if (busy !== 1'b0 || done !== 1'b0 || sel_valid !== 1'b0) begin
                nerr++;
                $display("FAIL mr_wait[%0d]: got v=%b b=%b d=%b want 0", j, sel_valid, busy, done);
            end
        end
        cfg(4'd10, 4'd11, 8'd1, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        nvec++;
        if (sel_out !== 4'd10 || busy !== 1'b1) begin
            nerr++;
            $display("FAIL mr_restart: got sel=%h b=%b want sel=a b=1", sel_out, busy);
        end
        step();
        nvec++;
        if (sel_out !== 4'd11) begin
            nerr++;
            $display("FAIL mr_restart_next: got sel=%h want b", sel_out);
        end
        step();
        nvec++;
        if (done !== 1'b1) begin
            nerr++;
            $display("FAIL mr_restart_done: got d=%b want 1", done);
        end
        step();
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_backpressure();
        test_loop_stop();
        test_start_stop_idle();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
